audio_i2s_tx: RTL

//   Serial audio transmitter downstream of the 2nd-order IIR filters. Accepts one filtered stereo

---
 rtl/audio_pkg.sv | 11 +
 rtl/audio_bit_clock_gen.sv | 62 ++++++
 rtl/audio_i2s_tx.sv | 104 ++++++++++
 3 files changed

// File: rtl/audio_pkg.sv
// Shared constants and types for the serial audio transmit path.
package audio_pkg;

    localparam int DEFAULT_SLOT_BITS = 32;

    typedef struct packed {
        logic signed [15:0] l;
        logic signed [15:0] r;
    } stereo16_t;

endpackage

// File: rtl/audio_bit_clock_gen.sv
// Bit-clock and frame timing for the I2S transmitter: divides clk into sclk,
// counts bit slots across a stereo frame, and flags the fall tick and frame load cycle.
module audio_bit_clock_gen
    import audio_pkg::*;
#(
    parameter int SLOT_BITS = DEFAULT_SLOT_BITS,
    parameter int SCLK_DIV  = 8
) (
    input  logic i_clk,
    input  logic i_rst,
    output logic o_sclk,
    output logic o_lrck,
    output logic o_fall_tick,
    output logic o_frame_load
);

    localparam int DIV_W = $clog2(SCLK_DIV);
    localparam int BIT_W = $clog2(2 * SLOT_BITS);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(SCLK_DIV / 2);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2 * SLOT_BITS - 1);
    localparam logic [BIT_W-1:0] SLOT     = BIT_W'(SLOT_BITS);

    logic [DIV_W-1:0] r_div;
    logic [BIT_W-1:0] r_bit;
    logic             r_sclk;
    logic             r_lrck;
    logic [DIV_W-1:0] w_div_nxt;
    logic [BIT_W-1:0] w_bit_nxt;
    logic             w_fall;

    always_comb begin
        w_fall    = (r_div == DIV_LAST);
        w_div_nxt = r_div + 1'b1;
        w_bit_nxt = r_bit;
        if (w_fall) begin
            w_div_nxt = '0;
            w_bit_nxt = (r_bit == BIT_LAST) ? '0 : r_bit + 1'b1;
        end
    end

    // sclk and lrck are computed from the next count so they stay aligned with the counters.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_div  <= '0;
            r_bit  <= '0;
            r_sclk <= 1'b0;
            r_lrck <= 1'b0;
        end else begin
            r_div  <= w_div_nxt;
            r_bit  <= w_bit_nxt;
            r_sclk <= (w_div_nxt >= DIV_HALF);
            r_lrck <= (w_bit_nxt >= SLOT);
        end
    end

    assign o_sclk       = r_sclk;
    assign o_lrck       = r_lrck;
    assign o_fall_tick  = w_fall;
    assign o_frame_load = (r_div == '0) && (r_bit == '0);

endmodule

// File: rtl/audio_i2s_tx.sv
// I2S transmitter: one pending stereo pair, frame shift register, zero-fill on underrun.
// Define AUDIO_TX_LJ_EN for left-justified output (no one-SCLK data delay).
module audio_i2s_tx
    import audio_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int SLOT_BITS  = DEFAULT_SLOT_BITS,
    parameter int SCLK_DIV   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_left,
    input  logic [DATA_WIDTH-1:0] in_right,
    output logic                  sclk,
    output logic                  lrck,
    output logic                  sdata,
    output logic                  underrun
);

    localparam int FW = 2 * SLOT_BITS;

    generate
        if (SLOT_BITS < DATA_WIDTH || SCLK_DIV < 2 || (SCLK_DIV % 2) != 0) begin : g_bad_param
            $error("audio_i2s_tx: need SLOT_BITS >= DATA_WIDTH and even SCLK_DIV >= 2");
        end
    endgenerate

    logic                  w_fall;
    logic                  w_frame_load;
    logic                  w_accept;
    logic [FW-1:0]         w_load;
    logic                  r_pend_full;
    logic [DATA_WIDTH-1:0] r_pend_l;
    logic [DATA_WIDTH-1:0] r_pend_r;
    logic [FW-1:0]         r_shreg;
    logic                  r_underrun;

    audio_bit_clock_gen #(
        .SLOT_BITS (SLOT_BITS),
        .SCLK_DIV  (SCLK_DIV)
    ) u_clk_gen (
        .i_clk        (clk),
        .i_rst        (reset),
        .o_sclk       (sclk),
        .o_lrck       (lrck),
        .o_fall_tick  (w_fall),
        .o_frame_load (w_frame_load)
    );

    // Each sample sits MSB-first at the top of its slot; the slot tail is zero.
    assign w_load   = (FW'(r_pend_l) << (FW - DATA_WIDTH))
                    | (FW'(r_pend_r) << (SLOT_BITS - DATA_WIDTH));
    assign w_accept = in_valid && !r_pend_full;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pend_full <= 1'b0;
            r_shreg     <= '0;
            r_underrun  <= 1'b0;
        end else begin
            r_underrun <= w_frame_load && !r_pend_full;
            if (w_frame_load) begin
                r_shreg <= r_pend_full ? w_load : '0;
            end else if (w_fall) begin
                r_shreg <= {r_shreg[FW-2:0], 1'b0};
            end
            // A full pending register blocks accepts, so load and accept cannot coincide.
            if (w_frame_load && r_pend_full) begin
                r_pend_full <= 1'b0;
            end else if (w_accept) begin
                r_pend_full <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_pend_l <= in_left;
            r_pend_r <= in_right;
        end
    end

`ifdef AUDIO_TX_LJ_EN
    assign sdata = r_shreg[FW-1];
`else
    logic r_sdata_dly;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sdata_dly <= 1'b0;
        end else if (w_fall) begin
            r_sdata_dly <= r_shreg[FW-1];
        end
    end

    assign sdata = r_sdata_dly;
`endif

    assign in_ready = !r_pend_full;
    assign underrun = r_underrun;

endmodule
